// File: rtl/channel_writer.sv
// channel_writer: one fixed-length INCR write burst per command.
// Each 512-bit input word is split into two 256-bit W beats, low half first.
module channel_writer #(
  parameter int LEN = 15,
  parameter int ID = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_cmd_in_valid,
  output logic         io_cmd_in_ready,
  input  logic [63:0]  io_cmd_in_bits_addr,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [511:0] io_in_bits_data,
  input  logic         io_in_bits_last,
  output logic         io_aw_valid,
  input  logic         io_aw_ready,
  output logic [32:0]  io_aw_bits_addr,
  output logic [1:0]   io_aw_bits_burst,
  output logic [3:0]   io_aw_bits_cache,
  output logic [5:0]   io_aw_bits_id,
  output logic [3:0]   io_aw_bits_len,
  output logic         io_aw_bits_lock,
  output logic [2:0]   io_aw_bits_prot,
  output logic [3:0]   io_aw_bits_qos,
  output logic [3:0]   io_aw_bits_region,
  output logic [2:0]   io_aw_bits_size,
  output logic         io_w_valid,
  input  logic         io_w_ready,
  output logic [255:0] io_w_bits_data,
  output logic [31:0]  io_w_bits_strb,
  output logic         io_w_bits_last,
  input  logic         io_b_valid,
  output logic         io_b_ready,
  input  logic [1:0]   io_b_bits_resp,
  input  logic [5:0]   io_b_bits_id,
  output logic         io_done,
  output logic         io_err_resp,
  output logic         io_err_last
);

  localparam int WORDS = (LEN + 1) / 2;
  localparam int WW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic          armed;
  logic [32:0]   addr;
  logic [511:0]  data_buf;
  logic          buf_v;
  logic          half;
  logic [3:0]    beat_cnt;
  logic [WW-1:0] words_left;
  logic          done;
  logic          err_resp;
  logic          err_last;

  logic cmd_rdy;
  logic aw_v;
  logic b_rdy;
  logic dat_act;
  logic w_v;
  logic in_rdy;
  logic w_last;
  logic cmd_fire;
  logic aw_fire;
  logic in_fire;
  logic w_fire;
  logic b_fire;
  logic unused_ok;

  assign unused_ok = ^{io_b_bits_id, io_cmd_in_bits_addr[63:33]};

  // armed keeps cmd ready low while reset is held and until the first edge
  always_comb begin
    state_nx = state;
    cmd_rdy  = 1'b0;
    aw_v     = 1'b0;
    b_rdy    = 1'b0;
    dat_act  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_rdy = armed;
        if (armed && io_cmd_in_valid) state_nx = ADDR;
      end
      ADDR: begin
        aw_v = 1'b1;
        if (io_aw_ready) state_nx = DATA;
      end
      DATA: begin
        dat_act = 1'b1;
        if (buf_v && io_w_ready && w_last) state_nx = RESP;
      end
      RESP: begin
        b_rdy = 1'b1;
        if (io_b_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign w_last = (beat_cnt == 4'(LEN));
  assign w_v    = dat_act && buf_v;
  assign in_rdy = dat_act && (words_left != '0) &&
                  (!buf_v || (half && io_w_ready));

  assign cmd_fire = io_cmd_in_valid && cmd_rdy;
  assign aw_fire  = aw_v && io_aw_ready;
  assign in_fire  = io_in_valid && in_rdy;
  assign w_fire   = w_v && io_w_ready;
  assign b_fire   = io_b_valid && b_rdy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      addr       <= '0;
      data_buf   <= '0;
      buf_v      <= 1'b0;
      half       <= 1'b0;
      beat_cnt   <= '0;
      words_left <= '0;
      done       <= 1'b0;
      err_resp   <= 1'b0;
      err_last   <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= b_fire;
      if (cmd_fire) addr <= io_cmd_in_bits_addr[32:0];
      if (aw_fire) begin
        words_left <= WW'(WORDS);
        beat_cnt   <= '0;
      end
      if (w_fire) beat_cnt <= beat_cnt + 4'd1;
      // a refill in the same cycle as the upper-half beat wins
      if (in_fire) begin
        data_buf   <= io_in_bits_data;
        buf_v      <= 1'b1;
        half       <= 1'b0;
        words_left <= words_left - WW'(1);
        if (io_in_bits_last != (words_left == WW'(1)))
          err_last <= 1'b1;
      end else if (w_fire) begin
        if (half) buf_v <= 1'b0;
        else      half  <= 1'b1;
      end
      if (b_fire && (io_b_bits_resp != 2'b00)) err_resp <= 1'b1;
    end
  end

  assign io_cmd_in_ready   = cmd_rdy;
  assign io_in_ready       = in_rdy;
  assign io_aw_valid       = aw_v;
  assign io_aw_bits_addr   = addr;
  assign io_aw_bits_burst  = 2'd1;
  assign io_aw_bits_cache  = 4'd0;
  assign io_aw_bits_id     = 6'(ID);
  assign io_aw_bits_len    = 4'(LEN);
  assign io_aw_bits_lock   = 1'b0;
  assign io_aw_bits_prot   = 3'd0;
  assign io_aw_bits_qos    = 4'd0;
  assign io_aw_bits_region = 4'd0;
  assign io_aw_bits_size   = 3'd5;
  assign io_w_valid        = w_v;
  assign io_w_bits_data    = half ? data_buf[511:256] : data_buf[255:0];
  assign io_w_bits_strb    = '1;
  assign io_w_bits_last    = w_last;
  assign io_b_ready        = b_rdy;
  assign io_done           = done;
  assign io_err_resp       = err_resp;
  assign io_err_last       = err_last;

endmodule

// File: tb/tb_channel_writer.sv
// tb_channel_writer: directed scenarios for channel_writer.
// A cycle driver records what happened; each test task checks it.
module tb_channel_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_cmd_in_valid = 1'b0;
  logic         io_cmd_in_ready;
  logic [63:0]  io_cmd_in_bits_addr = '0;
  logic         io_in_valid = 1'b0;
  logic         io_in_ready;
  logic [511:0] io_in_bits_data = '0;
  logic         io_in_bits_last = 1'b0;
  logic         io_aw_valid;
  logic         io_aw_ready = 1'b0;
  logic [32:0]  io_aw_bits_addr;
  logic [1:0]   io_aw_bits_burst;
  logic [3:0]   io_aw_bits_cache;
  logic [5:0]   io_aw_bits_id;
  logic [3:0]   io_aw_bits_len;
  logic         io_aw_bits_lock;
  logic [2:0]   io_aw_bits_prot;
  logic [3:0]   io_aw_bits_qos;
  logic [3:0]   io_aw_bits_region;
  logic [2:0]   io_aw_bits_size;
  logic         io_w_valid;
  logic         io_w_ready = 1'b0;
  logic [255:0] io_w_bits_data;
  logic [31:0]  io_w_bits_strb;
  logic         io_w_bits_last;
  logic         io_b_valid = 1'b0;
  logic         io_b_ready;
  logic [1:0]   io_b_bits_resp = '0;
  logic [5:0]   io_b_bits_id = '0;
  logic         io_done;
  logic         io_err_resp;
  logic         io_err_last;

  channel_writer #(.LEN(15), .ID(0)) dut (
    .clock(clock),
    .reset(reset),
    .io_cmd_in_valid(io_cmd_in_valid),
    .io_cmd_in_ready(io_cmd_in_ready),
    .io_cmd_in_bits_addr(io_cmd_in_bits_addr),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_bits_data(io_in_bits_data),
    .io_in_bits_last(io_in_bits_last),
    .io_aw_valid(io_aw_valid),
    .io_aw_ready(io_aw_ready),
    .io_aw_bits_addr(io_aw_bits_addr),
    .io_aw_bits_burst(io_aw_bits_burst),
    .io_aw_bits_cache(io_aw_bits_cache),
    .io_aw_bits_id(io_aw_bits_id),
    .io_aw_bits_len(io_aw_bits_len),
    .io_aw_bits_lock(io_aw_bits_lock),
    .io_aw_bits_prot(io_aw_bits_prot),
    .io_aw_bits_qos(io_aw_bits_qos),
    .io_aw_bits_region(io_aw_bits_region),
    .io_aw_bits_size(io_aw_bits_size),
    .io_w_valid(io_w_valid),
    .io_w_ready(io_w_ready),
    .io_w_bits_data(io_w_bits_data),
    .io_w_bits_strb(io_w_bits_strb),
    .io_w_bits_last(io_w_bits_last),
    .io_b_valid(io_b_valid),
    .io_b_ready(io_b_ready),
    .io_b_bits_resp(io_b_bits_resp),
    .io_b_bits_id(io_b_bits_id),
    .io_done(io_done),
    .io_err_resp(io_err_resp),
    .io_err_last(io_err_last)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0]  r_aw_addr;
  logic [3:0]   r_aw_len;
  logic [2:0]   r_aw_size;
  logic [1:0]   r_aw_burst;
  logic [255:0] r_data [16];
  logic [15:0]  r_last;
  int r_beats, r_cmd_cyc, r_aw_cyc, r_first_w, r_last_w;
  int r_b_cyc, r_done_cyc, r_done_n, r_stall_bad, r_busy_rdy;
  bit r_rdy_at_done, r_timeout, r_abort_bad;

  function automatic bit rnd(input int bp);
    return $urandom_range(0, 99) >= bp;
  endfunction

  task automatic idle_inputs();
    io_cmd_in_valid = 1'b0;
    io_in_valid = 1'b0;
    io_in_bits_last = 1'b0;
    io_aw_ready = 1'b0;
    io_w_ready = 1'b0;
    io_b_valid = 1'b0;
  endtask

  task automatic run_cmd(
    input logic [63:0]  addr,
    input logic [255:0] base,
    input int           bp,
    input logic [1:0]   resp,
    input int           bad_word,
    input bit           hold_cmd,
    input int           abort_at,
    input int           bdelay
  );
    int cyc = 0;
    int widx = 0;
    int b_start = -1;
    bit cmd_done = 0;
    bit aw_stall = 0;
    bit w_stall = 0;
    logic [32:0]  p_addr = '0;
    logic [255:0] p_data = '0;
    logic         p_last = 1'b0;
    r_beats = 0; r_cmd_cyc = -1; r_aw_cyc = -1;
    r_first_w = -1; r_last_w = -1; r_b_cyc = -1;
    r_done_cyc = -1; r_done_n = 0; r_stall_bad = 0;
    r_busy_rdy = 0; r_rdy_at_done = 0; r_timeout = 0;
    r_abort_bad = 0; r_last = '0;
    for (int i = 0; i < 16; i++) r_data[i] = 'x;
    forever begin
      @(negedge clock);
      io_cmd_in_valid = !cmd_done || hold_cmd;
      io_cmd_in_bits_addr = addr;
      io_aw_ready = rnd(bp);
      io_in_valid = (widx < 8) && rnd(bp);
      io_in_bits_data = {base + 256'(2 * widx + 1),
                         base + 256'(2 * widx)};
      io_in_bits_last = (bad_word >= 0) ? (widx == bad_word)
                                        : (widx == 7);
      io_w_ready = rnd(bp);
      io_b_valid = (b_start >= 0) && (cyc >= b_start);
      io_b_bits_resp = resp;
      io_b_bits_id = 6'(cyc);
      #1;
      if (aw_stall && !(io_aw_valid &&
          io_aw_bits_addr === p_addr)) r_stall_bad++;
      if (w_stall && !(io_w_valid && io_w_bits_data === p_data &&
          io_w_bits_last === p_last)) r_stall_bad++;
      if (cmd_done && !io_done && io_cmd_in_ready) r_busy_rdy++;
      if (io_done) begin
        r_done_n++;
        r_done_cyc = cyc;
        r_rdy_at_done = io_cmd_in_ready;
      end
      if (!cmd_done && io_cmd_in_valid && io_cmd_in_ready) begin
        cmd_done = 1;
        r_cmd_cyc = cyc;
      end
      if (io_aw_valid && io_aw_ready) begin
        r_aw_cyc = cyc;
        r_aw_addr = io_aw_bits_addr;
        r_aw_len = io_aw_bits_len;
        r_aw_size = io_aw_bits_size;
        r_aw_burst = io_aw_bits_burst;
      end
      if (io_w_valid && io_w_ready) begin
        if (r_first_w < 0) r_first_w = cyc;
        if (r_beats < 16) begin
          r_data[r_beats] = io_w_bits_data;
          r_last[r_beats] = io_w_bits_last;
        end
        if (io_w_bits_last) begin
          r_last_w = cyc;
          b_start = cyc + 1 + bdelay;
        end
        r_beats++;
      end
      if (io_in_valid && io_in_ready) widx++;
      if (io_b_valid && io_b_ready) begin
        r_b_cyc = cyc;
        b_start = -1;
      end
      aw_stall = io_aw_valid && !io_aw_ready;
      p_addr = io_aw_bits_addr;
      w_stall = io_w_valid && !io_w_ready;
      p_data = io_w_bits_data;
      p_last = io_w_bits_last;
      if (abort_at >= 0 && r_beats == abort_at) begin
        #2 reset = 1'b1;
        #1;
        r_abort_bad = io_cmd_in_ready | io_in_ready | io_aw_valid |
                      io_w_valid | io_b_ready | io_done |
                      io_err_resp | io_err_last;
        idle_inputs();
        return;
      end
      if (io_done) begin
        idle_inputs();
        return;
      end
      cyc++;
      if (cyc > 500) begin
        r_timeout = 1;
        idle_inputs();
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if ({io_cmd_in_ready, io_in_ready, io_aw_valid, io_w_valid,
         io_b_ready, io_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_hs: got %b want 000000",
        {io_cmd_in_ready, io_in_ready, io_aw_valid, io_w_valid,
         io_b_ready, io_done});
    end
    n_cmp++;
    if ({io_err_resp, io_err_last} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_err: got %b want 00",
        {io_err_resp, io_err_last});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (io_cmd_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle_ready: got %b want 1", io_cmd_in_ready);
    end
  endtask

  task automatic test_basic();
    run_cmd(64'h1000, 256'd0, 0, 2'b00, -1, 0, -1, 0);
    n_cmp++;
    if (r_timeout !== 1'b0) begin
      n_err++; $display("FAIL basic_timeout: got 1 want 0");
    end
    n_cmp++;
    if (r_aw_addr !== 33'h1000) begin
      n_err++; $display("FAIL basic_aw_addr: got %h want 1000", r_aw_addr);
    end
    n_cmp++;
    if ({r_aw_len, r_aw_size, r_aw_burst} !== {4'd15, 3'd5, 2'd1}) begin
      n_err++;
      $display("FAIL basic_aw_fields: got len %0d size %0d burst %0d want 15 5 1",
        r_aw_len, r_aw_size, r_aw_burst);
    end
    n_cmp++;
    if (io_w_bits_strb !== 32'hFFFF_FFFF || io_aw_bits_id !== 6'd0) begin
      n_err++;
      $display("FAIL basic_strb_id: got %h %0d want ffffffff 0",
        io_w_bits_strb, io_aw_bits_id);
    end
    n_cmp++;
    if (r_beats !== 16) begin
      n_err++; $display("FAIL basic_beats: got %0d want 16", r_beats);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (r_data[j] !== 256'(j)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got %0h want %0h", j, r_data[j], j);
      end
    end
    n_cmp++;
    if (r_last !== 16'h8000) begin
      n_err++; $display("FAIL basic_wlast: got %h want 8000", r_last);
    end
    n_cmp++;
    if ({r_aw_cyc, r_first_w, r_last_w} !== {32'd1, 32'd3, 32'd18}) begin
      n_err++;
      $display("FAIL basic_timing: got aw %0d w0 %0d w15 %0d want 1 3 18",
        r_aw_cyc, r_first_w, r_last_w);
    end
    n_cmp++;
    if (r_b_cyc !== 19 || r_done_cyc !== 20) begin
      n_err++;
      $display("FAIL basic_done_cyc: got b %0d done %0d want 19 20",
        r_b_cyc, r_done_cyc);
    end
    n_cmp++;
    if (r_rdy_at_done !== 1'b1) begin
      n_err++; $display("FAIL basic_ready_at_done: got 0 want 1");
    end
    n_cmp++;
    if ({io_err_resp, io_err_last} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_err: got %b want 00", {io_err_resp, io_err_last});
    end
  endtask

  task automatic test_backpressure();
    int dones = 0;
    logic [255:0] base;
    for (int c = 0; c < 3; c++) begin
      base = 256'(1000 * (c + 1));
      run_cmd(64'hABCD_0001_2345_6000 + 64'(c * 'h200), base,
              50, 2'b00, -1, 0, -1, c);
      dones += r_done_n;
      n_cmp++;
      if (r_aw_addr !== 33'h1_2345_6000 + 33'(c * 'h200)) begin
        n_err++;
        $display("FAIL bp_aw_addr%0d: got %h want %h", c, r_aw_addr,
          33'h1_2345_6000 + 33'(c * 'h200));
      end
      n_cmp++;
      if (r_beats !== 16 || r_last !== 16'h8000) begin
        n_err++;
        $display("FAIL bp_beats%0d: got %0d last %h want 16 8000",
          c, r_beats, r_last);
      end
      for (int j = 0; j < 16; j++) begin
        n_cmp++;
        if (r_data[j] !== base + 256'(j)) begin
          n_err++;
          $display("FAIL bp_beat%0d_%0d: got %0h want %0h",
            c, j, r_data[j], base + 256'(j));
        end
      end
      n_cmp++;
      if (r_stall_bad !== 0) begin
        n_err++;
        $display("FAIL bp_stable%0d: got %0d changes want 0", c, r_stall_bad);
      end
    end
    n_cmp++;
    if (dones !== 3) begin
      n_err++; $display("FAIL bp_dones: got %0d want 3", dones);
    end
  endtask

  task automatic test_err_resp();
    int dones = 0;
    run_cmd(64'h2000, 256'd0, 0, 2'b00, -1, 0, -1, 2);
    dones += r_done_n;
    n_cmp++;
    if (io_err_resp !== 1'b0) begin
      n_err++; $display("FAIL resp_ok_flag: got 1 want 0");
    end
    run_cmd(64'h3000, 256'd0, 0, 2'b10, -1, 0, -1, 0);
    dones += r_done_n;
    n_cmp++;
    if (io_err_resp !== 1'b1) begin
      n_err++; $display("FAIL resp_err_flag: got %b want 1", io_err_resp);
    end
    n_cmp++;
    if (dones !== 2) begin
      n_err++; $display("FAIL resp_dones: got %0d want 2", dones);
    end
  endtask

  task automatic test_framing();
    n_cmp++;
    if (io_err_last !== 1'b0) begin
      n_err++; $display("FAIL frame_pre: got %b want 0", io_err_last);
    end
    run_cmd(64'h4000, 256'd500, 0, 2'b00, 2, 0, -1, 0);
    n_cmp++;
    if (io_err_last !== 1'b1) begin
      n_err++; $display("FAIL frame_flag: got %b want 1", io_err_last);
    end
    n_cmp++;
    if (r_beats !== 16 || r_done_n !== 1) begin
      n_err++;
      $display("FAIL frame_complete: got beats %0d done %0d want 16 1",
        r_beats, r_done_n);
    end
    n_cmp++;
    if (r_data[15] !== 256'd515) begin
      n_err++; $display("FAIL frame_last_beat: got %0d want 515", r_data[15]);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(64'h5000, 256'd0, 0, 2'b00, -1, 1, -1, 3);
    n_cmp++;
    if (r_busy_rdy !== 0) begin
      n_err++;
      $display("FAIL b2b_busy_ready: got %0d cycles want 0", r_busy_rdy);
    end
    n_cmp++;
    if (r_rdy_at_done !== 1'b1 || r_done_n !== 1) begin
      n_err++;
      $display("FAIL b2b_ready_at_done: got %b done %0d want 1 1",
        r_rdy_at_done, r_done_n);
    end
    run_cmd(64'h6000, 256'd0, 0, 2'b00, -1, 0, -1, 0);
    n_cmp++;
    if (r_cmd_cyc !== 0 || r_aw_addr !== 33'h6000) begin
      n_err++;
      $display("FAIL b2b_second: got cyc %0d addr %h want 0 6000",
        r_cmd_cyc, r_aw_addr);
    end
  endtask

  task automatic test_reset_abort();
    run_cmd(64'h7000, 256'd0, 0, 2'b00, -1, 0, 7, 0);
    n_cmp++;
    if (r_beats !== 7) begin
      n_err++; $display("FAIL abort_reached: got %0d want 7", r_beats);
    end
    n_cmp++;
    if (r_abort_bad !== 1'b0) begin
      n_err++; $display("FAIL abort_async_zero: got 1 want 0");
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    io_w_ready = 1'b1;
    io_b_valid = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({io_w_valid, io_b_ready, io_aw_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_no_partial: got %b want 000",
        {io_w_valid, io_b_ready, io_aw_valid});
    end
    idle_inputs();
    run_cmd(64'h8000, 256'd40, 0, 2'b00, -1, 0, -1, 0);
    n_cmp++;
    if (r_beats !== 16 || r_done_n !== 1 || r_data[0] !== 256'd40 ||
        r_data[15] !== 256'd55) begin
      n_err++;
      $display("FAIL abort_recover: got beats %0d done %0d want 16 1",
        r_beats, r_done_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_err_resp();
    test_framing();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
